mem_port_arbiter: RTL and testbench

- Shares one single-port memory (MemUnit-style: vptr, write enable, store data, load data) between the instruction fetcher and the load/store unit.
- Accepts one request at a time using a req/gnt handshake and counts the fixed memory latency.
- Routes the load data back to the requester that owns the access. Fetch responses can be cancelled by a flush.
- Sits between the Fetcher/LSU and the memory so that the core can run with a unified instruction/data memory.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_priority_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_LSU
  } owner_e;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner selection between fetch and LSU for one memory slot.
module arb_priority_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = 3
) (
  input  logic                grant_en,
  input  logic                fetch_req,
  input  logic                fetch_flush,
  input  logic                lsu_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                fetch_gnt,
  output logic                lsu_gnt
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic fetch_live;
  logic fetch_priority;

  always_comb begin
    // A flushed fetch is treated as absent so it can never take the slot.
    fetch_live     = fetch_req & ~fetch_flush;
    fetch_priority = (starve_cnt == STARVE_MAX);
    lsu_gnt        = grant_en & lsu_req & ~(fetch_live & fetch_priority);
    fetch_gnt      = grant_en & fetch_live & (~lsu_req | fetch_priority);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetcher and the LSU,
// one access in flight at a time, routing load data back to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            _clk,
  input  logic            _reset,
  input  logic            _fetch_req,
  input  logic [XLEN-1:0] _fetch_addr,
  input  logic            _fetch_flush,
  output logic            fetch_gnt_,
  output logic            fetch_rvalid_,
  output logic [XLEN-1:0] fetch_rdata_,
  input  logic            _lsu_req,
  input  logic            _lsu_we,
  input  logic [XLEN-1:0] _lsu_addr,
  input  logic [XLEN-1:0] _lsu_wdata,
  output logic            lsu_gnt_,
  output logic            lsu_rvalid_,
  output logic [XLEN-1:0] lsu_rdata_,
  output logic [XLEN-1:0] mem_vptr_,
  output logic            mem_we_,
  output logic [XLEN-1:0] mem_sw_data_,
  input  logic [XLEN-1:0] _mem_lw_data
);

  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  owner_e              owner_reg, owner_next;
  logic                write_reg, write_next;
  logic                flush_pend_reg, flush_pend_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic [XLEN-1:0]     vptr_reg, sw_data_reg;
  logic [XLEN-1:0]     fetch_rdata_reg, lsu_rdata_reg;

  logic grant_en;
  logic any_gnt;
  logic fetch_live;
  logic capture;
  logic fetch_drop;

  assign grant_en = ((state_reg == ARB_IDLE) || (state_reg == ARB_RESP)) && !_reset;

  arb_priority_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (STARVE_W)
  ) u_pick (
    .grant_en    (grant_en),
    .fetch_req   (_fetch_req),
    .fetch_flush (_fetch_flush),
    .lsu_req     (_lsu_req),
    .starve_cnt  (starve_reg),
    .fetch_gnt   (fetch_gnt_),
    .lsu_gnt     (lsu_gnt_)
  );

  assign any_gnt    = fetch_gnt_ | lsu_gnt_;
  assign fetch_live = _fetch_req & ~_fetch_flush;
  assign capture    = (state_reg == ARB_WAIT) && (cnt_reg == '0);
  // A flush arriving in the very cycle the data is valid still drops it.
  assign fetch_drop = flush_pend_reg | _fetch_flush;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    owner_next      = owner_reg;
    write_next      = write_reg;
    flush_pend_next = flush_pend_reg;
    starve_next     = starve_reg;

    case (state_reg)
      ARB_IDLE, ARB_RESP: begin
        if (any_gnt) begin
          state_next      = ARB_WAIT;
          cnt_next        = CNT_LOAD;
          owner_next      = lsu_gnt_ ? OWN_LSU : OWN_FETCH;
          write_next      = _lsu_we & lsu_gnt_;
          flush_pend_next = 1'b0;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if ((owner_reg == OWN_FETCH) && _fetch_flush) flush_pend_next = 1'b1;
        if (cnt_reg == '0) state_next = ARB_RESP;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = ARB_IDLE;
    endcase

    if (fetch_gnt_)
      starve_next = '0;
    else if (lsu_gnt_ && fetch_live && (starve_reg != STARVE_MAX))
      starve_next = starve_reg + STARVE_W'(1);
  end

  always_comb begin
    mem_we_      = _lsu_we & lsu_gnt_;
    mem_vptr_    = vptr_reg;
    mem_sw_data_ = sw_data_reg;
    if (any_gnt) begin
      mem_vptr_    = lsu_gnt_ ? _lsu_addr : _fetch_addr;
      mem_sw_data_ = _lsu_wdata;
    end
  end

  always_ff @(posedge _clk) begin
    if (_reset) begin
      state_reg       <= ARB_IDLE;
      cnt_reg         <= '0;
      owner_reg       <= OWN_FETCH;
      write_reg       <= 1'b0;
      flush_pend_reg  <= 1'b0;
      starve_reg      <= '0;
      vptr_reg        <= '0;
      sw_data_reg     <= '0;
      fetch_rdata_reg <= '0;
      lsu_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      write_reg      <= write_next;
      flush_pend_reg <= flush_pend_next;
      starve_reg     <= starve_next;
      if (any_gnt) begin
        vptr_reg    <= mem_vptr_;
        sw_data_reg <= _lsu_wdata;
      end
      if (capture) begin
        if ((owner_reg == OWN_FETCH) && !fetch_drop) fetch_rdata_reg <= _mem_lw_data;
        if ((owner_reg == OWN_LSU) && !write_reg)    lsu_rdata_reg   <= _mem_lw_data;
      end
    end
  end

  assign fetch_rvalid_ = (state_reg == ARB_RESP) && (owner_reg == OWN_FETCH) && !flush_pend_reg;
  assign lsu_rvalid_   = (state_reg == ARB_RESP) && (owner_reg == OWN_LSU);
  assign fetch_rdata_  = fetch_rdata_reg;
  assign lsu_rdata_    = lsu_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model
// of the shared memory port.
module tb_mem_port_arbiter;

  localparam int LAT = 3;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush, lsu_req, lsu_we;
  logic [31:0] fetch_addr, lsu_addr, lsu_wdata, mem_lw_data;
  logic        fetch_gnt, fetch_rvalid, lsu_gnt, lsu_rvalid, mem_we;
  logic [31:0] fetch_rdata, lsu_rdata, mem_vptr, mem_sw_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (SL)
  ) dut (
    ._clk          (clk),
    ._reset        (rst),
    ._fetch_req    (fetch_req),
    ._fetch_addr   (fetch_addr),
    ._fetch_flush  (fetch_flush),
    .fetch_gnt_    (fetch_gnt),
    .fetch_rvalid_ (fetch_rvalid),
    .fetch_rdata_  (fetch_rdata),
    ._lsu_req      (lsu_req),
    ._lsu_we       (lsu_we),
    ._lsu_addr     (lsu_addr),
    ._lsu_wdata    (lsu_wdata),
    .lsu_gnt_      (lsu_gnt),
    .lsu_rvalid_   (lsu_rvalid),
    .lsu_rdata_    (lsu_rdata),
    .mem_vptr_     (mem_vptr),
    .mem_we_       (mem_we),
    .mem_sw_data_  (mem_sw_data),
    ._mem_lw_data  (mem_lw_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one outstanding access and a word-addressed memory.
  int          cyc = 0;
  int          next_free = 0;
  int          starve = 0;
  bit          m_has = 0, m_lsu = 0, m_we = 0, m_flushed = 0;
  int          m_resp_cyc = 0;
  logic [31:0] m_readval = '0;
  logic [31:0] hold_vptr = '0, hold_swd = '0, exp_frd = '0, exp_lrd = '0;
  logic [31:0] memarr [32];

  bit          obs_fgnt, obs_lgnt, obs_frv, obs_lrv, obs_mwe;
  logic [31:0] obs_frd, obs_lrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          allow, fe, g_f, g_l, e_frv, e_lrv;
    logic [31:0] e_vptr, e_swd;
    int          idx;
    mem_lw_data = (m_has && cyc == m_resp_cyc - 1) ? m_readval : $urandom();
    @(negedge clk);
    allow = !rst && (cyc >= next_free);
    fe    = fetch_req && !fetch_flush;
    g_f = 1'b0;
    g_l = 1'b0;
    if (allow) begin
      if (lsu_req && fe) begin
        if (starve == SL) g_f = 1'b1;
        else              g_l = 1'b1;
      end else if (lsu_req) g_l = 1'b1;
      else if (fe)          g_f = 1'b1;
    end
    if (m_has && !m_lsu && cyc < m_resp_cyc && fetch_flush) m_flushed = 1'b1;
    e_frv  = m_has && (cyc == m_resp_cyc) && !m_lsu && !m_flushed;
    e_lrv  = m_has && (cyc == m_resp_cyc) && m_lsu;
    e_vptr = g_l ? lsu_addr : (g_f ? fetch_addr : hold_vptr);
    e_swd  = (g_l || g_f) ? lsu_wdata : hold_swd;

    chk("fetch_gnt", 32'(fetch_gnt), 32'(g_f));
    chk("lsu_gnt", 32'(lsu_gnt), 32'(g_l));
    chk("mem_we", 32'(mem_we), 32'(g_l && lsu_we));
    chk("mem_vptr", mem_vptr, e_vptr);
    chk("mem_sw_data", mem_sw_data, e_swd);
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(e_frv));
    chk("lsu_rvalid", 32'(lsu_rvalid), 32'(e_lrv));
    chk("lsu_rdata", lsu_rdata, exp_lrd);
    if (e_frv) chk("fetch_rdata", fetch_rdata, exp_frd);

    obs_fgnt = fetch_gnt;   obs_lgnt = lsu_gnt;
    obs_frv  = fetch_rvalid; obs_lrv = lsu_rvalid;
    obs_mwe  = mem_we;
    obs_frd  = fetch_rdata; obs_lrd = lsu_rdata;

    if (rst) begin
      next_free = cyc + 1;
      starve    = 0;
      m_has     = 1'b0;
      hold_vptr = '0;
      hold_swd  = '0;
      exp_frd   = '0;
      exp_lrd   = '0;
    end else begin
      if (m_has && cyc == m_resp_cyc - 1) begin
        if (!m_lsu && !m_flushed) exp_frd = m_readval;
        if (m_lsu && !m_we)       exp_lrd = m_readval;
      end
      if (m_has && cyc >= m_resp_cyc) m_has = 1'b0;
      if (g_l || g_f) begin
        if (g_l && fe) starve = (starve < SL) ? starve + 1 : SL;
        if (g_f)       starve = 0;
        idx        = int'(e_vptr[6:2]);
        m_has      = 1'b1;
        m_lsu      = g_l;
        m_we       = g_l && lsu_we;
        m_flushed  = 1'b0;
        m_resp_cyc = cyc + LAT + 1;
        m_readval  = memarr[idx];
        if (m_we) memarr[idx] = lsu_wdata;
        hold_vptr  = e_vptr;
        hold_swd   = lsu_wdata;
        next_free  = cyc + LAT + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    fetch_req = 1'b0; lsu_req = 1'b0; fetch_flush = 1'b0;
    repeat (LAT + 2) cycle();
  endtask

  initial begin
    string pat;
    byte   got;
    for (int i = 0; i < 32; i++) memarr[i] = $urandom();
    memarr[4] = 32'h0050_0093;
    rst = 1'b1;
    fetch_req = 1'b0; fetch_flush = 1'b0; fetch_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    mem_lw_data = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("rst_lsu_gnt", 32'(lsu_gnt), 32'd0);
    chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_vptr", mem_vptr, 32'd0);
    chk("rst_mem_sw_data", mem_sw_data, 32'd0);
    chk("rst_fetch_rdata", fetch_rdata, 32'd0);
    cycle();
    rst = 1'b0;

    // Fetch-only read of 0x10
    fetch_req = 1'b1; fetch_addr = 32'h10;
    cycle();
    chk("fo_gnt", 32'(obs_fgnt), 32'd1);
    fetch_req = 1'b0;
    repeat (LAT) begin
      cycle();
      chk("fo_no_rvalid", 32'(obs_frv), 32'd0);
    end
    cycle();
    chk("fo_rvalid", 32'(obs_frv), 32'd1);
    chk("fo_rdata", obs_frd, 32'h0050_0093);
    cycle();
    chk("fo_rvalid_once", 32'(obs_frv), 32'd0);
    drain();

    // Store then load at 0x40
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("st_gnt", 32'(obs_lgnt), 32'd1);
    chk("st_we", 32'(obs_mwe), 32'd1);
    lsu_we = 1'b0; lsu_wdata = '0;
    repeat (LAT) begin
      cycle();
      chk("st_wait_we", 32'(obs_mwe), 32'd0);
      chk("st_wait_gnt", 32'(obs_lgnt), 32'd0);
    end
    cycle();
    chk("st_ack", 32'(obs_lrv), 32'd1);
    chk("ld_gnt", 32'(obs_lgnt), 32'd1);
    chk("ld_we", 32'(obs_mwe), 32'd0);
    lsu_req = 1'b0;
    repeat (LAT) cycle();
    cycle();
    chk("ld_rvalid", 32'(obs_lrv), 32'd1);
    chk("ld_rdata", obs_lrd, 32'hDEAD_BEEF);
    drain();

    // Continuous conflict: four LSU wins, then fetch, then LSU again
    pat = "LLLLFL";
    fetch_req = 1'b1; fetch_addr = 32'h20;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h24;
    for (int k = 0; k < 6; k++) begin
      got = "?";
      for (int w = 0; w < 10 && got == "?"; w++) begin
        cycle();
        if (obs_lgnt)      got = "L";
        else if (obs_fgnt) got = "F";
      end
      chk("conflict_order", 32'(got), 32'(pat[k]));
    end
    drain();

    // Flush one cycle after a fetch grant
    fetch_req = 1'b1; fetch_addr = 32'h08;
    cycle();
    chk("fl_gnt", 32'(obs_fgnt), 32'd1);
    fetch_flush = 1'b1; fetch_addr = 32'h0C;
    cycle();
    chk("fl_gnt_blocked", 32'(obs_fgnt), 32'd0);
    fetch_flush = 1'b0;
    repeat (LAT - 1) begin
      cycle();
      chk("fl_wait_rvalid", 32'(obs_frv), 32'd0);
    end
    cycle();
    chk("fl_dropped", 32'(obs_frv), 32'd0);
    chk("fl_regrant", 32'(obs_fgnt), 32'd1);
    fetch_req = 1'b0;
    drain();

    // Reset while an LSU load is waiting
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h40;
    cycle();
    chk("rw_gnt", 32'(obs_lgnt), 32'd1);
    lsu_req = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    lsu_req = 1'b1; lsu_addr = 32'h44;
    cycle();
    chk("rw_post_gnt", 32'(obs_lgnt), 32'd1);
    chk("rw_post_lrv", 32'(obs_lrv), 32'd0);
    chk("rw_post_frv", 32'(obs_frv), 32'd0);
    chk("rw_post_lrd", obs_lrd, 32'd0);
    chk("rw_post_frd", obs_frd, 32'd0);
    lsu_req = 1'b0;
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (obs_fgnt || fetch_flush || !fetch_req) begin
        fetch_req  = ($urandom_range(0, 3) != 0);
        fetch_addr = 32'($urandom_range(0, 31)) << 2;
      end
      fetch_flush = ($urandom_range(0, 9) == 0);
      if (obs_lgnt || !lsu_req) begin
        lsu_req   = ($urandom_range(0, 2) != 0);
        lsu_we    = $urandom_range(0, 1) != 0;
        lsu_addr  = 32'($urandom_range(0, 31)) << 2;
        lsu_wdata = $urandom();
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
